addr_mode_sequencer: RTL and testbench
======================================

ADDR_MODE_SEQUENCER -- requirements
Module: addr_mode_sequencer

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 8, data/index register width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, bus address width; SHALL equal 2*REG_WIDTH, otherwise elaboration $fatal.
REQ-003 Port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-004 Port reset, input, 1, synchronous, active-high reset, sampled on posedge clk.
REQ-005 Port start, input, 1; opcode_in valid, sampled only in IDLE.
REQ-006 Port opcode_in, input, REG_WIDTH; raw opcode; mode = bits [4:2].
REQ-007 Port need_data, input, 1; sampled with start; 1 = fetch operand data at EA (loads/ALU), 0 = EA only (stores).
REQ-008 Port pc_in, input, ADDR_WIDTH; opcode address, sampled with start.
REQ-009 Ports x_in, y_in, input, REG_WIDTH each; index registers, sampled with start.
REQ-010 Ports mem_req (output, 1), mem_addr (output, ADDR_WIDTH), mem_ack (input, 1), mem_rdata (input, REG_WIDTH); read-only bus.
REQ-011 Ports busy (output, 1), done (output, 1), ea (output, ADDR_WIDTH), operand (output, REG_WIDTH), page_cross (output, 1), pc_adv (output, 2), add_mode (output, 3).

Function
REQ-012 Mode map [4:2]: 000 X_IND, 001 ZPG, 010 IMM, 011 ABS, 100 IND_Y, 101 ZPG_X, 110 ABS_Y, 111 ABS_X.
REQ-013 States: IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, FIXUP, DATA, DONE.
REQ-014 IDLE + start: latch inputs, go OP_LO; busy=1 from next cycle until DONE exits.
REQ-015 mem_req and mem_addr held stable until the cycle mem_ack=1; mem_rdata captured that cycle; state advances next cycle.
REQ-016 OP_LO reads pc+1; OP_HI (ABS, ABS_X, ABS_Y only) reads pc+2; pc_adv = 1 or 2 accordingly.
REQ-017 IMM: operand = byte at pc+1, ea = pc+1, DATA skipped regardless of need_data.
REQ-018 ZPG: ea = {0, op}; ZPG_X: ea = {0, (op+x) mod 2^REG_WIDTH}, no page_cross.
REQ-019 X_IND: PTR_LO reads {0,(op+x) mod 2^REG_WIDTH}, PTR_HI reads {0,(op+x+1) mod 2^REG_WIDTH}; ea = {hi,lo}.
REQ-020 IND_Y: PTR_LO reads {0,op}, PTR_HI reads {0,(op+1) mod 2^REG_WIDTH}; ea = {hi,lo}+y mod 2^ADDR_WIDTH.
REQ-021 ABS_X/ABS_Y: ea = {hi,lo}+index mod 2^ADDR_WIDTH.
REQ-022 page_cross=1 when index add carries out of low byte (ABS_X, ABS_Y, IND_Y); SHALL insert exactly one FIXUP cycle (mem_req=0) before DATA/DONE.
REQ-023 need_data=1 (non-IMM): DATA reads ea, operand = mem_rdata; need_data=0: operand = 0.
REQ-024 DONE: done=1 for exactly one cycle, ea/operand/page_cross/pc_adv/add_mode valid and held until next start accepted; then IDLE.
REQ-025 Zero-wait latency from start cycle T to done: IMM T+2; ZPG/ZPG_X T+2 (+1 data); ABS* T+3 (+1 data, +1 fixup); X_IND/IND_Y T+4 (+1 data, +1 fixup).
REQ-026 start while busy SHALL be ignored; start in the DONE cycle ignored.
REQ-027 Unlimited mem_ack wait states SHALL be tolerated with no timeout.

Reset
REQ-028 reset SHALL force IDLE in the next cycle, including mid-transaction; mem_req drops immediately with it.
REQ-029 Reset values: mem_req 0, mem_addr 0, busy 0, done 0, ea 0, operand 0, page_cross 0, pc_adv 0, add_mode 0.
REQ-030 reset concurrent with start: reset wins, start discarded.

Structure
REQ-031 AM3_* mode encodings, state encodings, REG_WIDTH/ADDR_WIDTH defaults SHALL live in the shared defines header with existing `define constants.
REQ-032 One sub-module ea_index_adder: base (ADDR_WIDTH) + index (REG_WIDTH), zero-page wrap select -> sum, page_cross; purely combinational.

Verification
REQ-033 IMM opcode 0xA9, pc 0x0200, mem[0x0201]=0x42, zero-wait -> done at T+2, operand 0x42, ea 0x0201, pc_adv 1.
REQ-034 ZPG_X 0xB5, op 0xF0, x 0x20, need_data -> reads 0x0010 (wrap), page_cross 0, done T+3.
REQ-035 ABS_X 0xBD, bytes 0xFF,0x12, x 0x01 -> ea 0x1300, page_cross 1, FIXUP seen, done T+5 with data.
REQ-036 IND_Y 0xB1, op 0xFF, mem[0x00FF]=0x00, mem[0x0000]=0x30, y 0x05, need_data=0 -> ptr hi from 0x0000, ea 0x3005, done T+4.
REQ-037 X_IND with 3 wait states per access, reset asserted during PTR_HI -> mem_req low, IDLE next cycle, no done pulse; fresh start then completes normally.
REQ-038 start pulsed during busy -> ignored; first transaction's ea unchanged.

Source files
------------

// File: rtl/addr_mode_sequencer_pkg.sv
// Shared constants and types for the addressing-mode sequencer.
package addr_mode_sequencer_pkg;

    localparam int unsigned REG_WIDTH_DEF  = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 16;

    // Addressing mode, taken from opcode bits [4:2]
    typedef enum logic [2:0] {
        AM3_X_IND = 3'b000,
        AM3_ZPG   = 3'b001,
        AM3_IMM   = 3'b010,
        AM3_ABS   = 3'b011,
        AM3_IND_Y = 3'b100,
        AM3_ZPG_X = 3'b101,
        AM3_ABS_Y = 3'b110,
        AM3_ABS_X = 3'b111
    } am3_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OP_LO  = 3'd1,
        ST_OP_HI  = 3'd2,
        ST_PTR_LO = 3'd3,
        ST_PTR_HI = 3'd4,
        ST_FIXUP  = 3'd5,
        ST_DATA   = 3'd6,
        ST_DONE   = 3'd7
    } seq_state_e;

    // Modes carrying a two-byte operand after the opcode
    function automatic logic is_abs_mode(input am3_e m);
        return (m == AM3_ABS) || (m == AM3_ABS_X) || (m == AM3_ABS_Y);
    endfunction

    // Modes whose index add can cross a page
    function automatic logic can_page_cross(input am3_e m);
        return (m == AM3_ABS_X) || (m == AM3_ABS_Y) || (m == AM3_IND_Y);
    endfunction

endpackage

// File: rtl/addr_mode_sequencer_ea_index_adder.sv
// Base + index adder with optional zero-page wrap and low-byte carry detect.
module ea_index_adder #(
    parameter int unsigned REG_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [REG_WIDTH-1:0]  index,
    input  logic                  zp_wrap,
    output logic [ADDR_WIDTH-1:0] sum,
    output logic                  page_cross
);

    logic [REG_WIDTH:0] lo_sum;

    // Low-byte add gives both the zero-page result and the page-cross carry
    always_comb begin
        lo_sum = {1'b0, base[REG_WIDTH-1:0]} + {1'b0, index};
        if (zp_wrap) begin
            sum        = ADDR_WIDTH'(lo_sum[REG_WIDTH-1:0]);
            page_cross = 1'b0;
        end else begin
            sum        = base + ADDR_WIDTH'(index);
            page_cross = lo_sum[REG_WIDTH];
        end
    end

endmodule

// File: rtl/addr_mode_sequencer.sv
// Walks the operand/pointer/data bus reads for one addressing mode and reports the EA.
module addr_mode_sequencer
    import addr_mode_sequencer_pkg::*;
#(
    parameter int unsigned REG_WIDTH  = REG_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [REG_WIDTH-1:0]  opcode_in,
    input  logic                  need_data,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [REG_WIDTH-1:0]  x_in,
    input  logic [REG_WIDTH-1:0]  y_in,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ea,
    output logic [REG_WIDTH-1:0]  operand,
    output logic                  page_cross,
    output logic [1:0]            pc_adv,
    output logic [2:0]            add_mode
);

    if (ADDR_WIDTH != 2 * REG_WIDTH) begin : g_width_check
        $fatal(1, "addr_mode_sequencer: ADDR_WIDTH must equal 2*REG_WIDTH");
    end

    seq_state_e            state_q, state_d;
    am3_e                  mode_q, mode_d;
    logic                  need_q, need_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [REG_WIDTH-1:0]  x_q, x_d, y_q, y_d, op_q, op_d, lo_q, lo_d;
    logic [ADDR_WIDTH-1:0] ea_d, mem_addr_d;
    logic [REG_WIDTH-1:0]  operand_d;
    logic                  page_cross_d, mem_req_d;
    logic [1:0]            pc_adv_d;

    logic [ADDR_WIDTH-1:0] add_base_c, add_sum_c;
    logic [REG_WIDTH-1:0]  add_index_c;
    logic                  add_zp_c, add_cross_c;
    logic [REG_WIDTH-1:0]  ptr_op_c, ptr_lo_c, ptr_hi_c;
    logic                  addr_done_c;
    logic                  unused_opcode_bits_c;

    assign add_mode             = mode_q;
    assign unused_opcode_bits_c = ^{opcode_in[REG_WIDTH-1:5], opcode_in[1:0]};

    // Final EA operands: taken from the byte arriving on this cycle's ack
    always_comb begin
        add_base_c  = {mem_rdata, lo_q};
        add_index_c = '0;
        add_zp_c    = 1'b0;
        case (mode_q)
            AM3_IMM:   begin add_base_c = pc_q; add_index_c = REG_WIDTH'(1); end
            AM3_ZPG:   begin add_base_c = ADDR_WIDTH'(mem_rdata); add_zp_c = 1'b1; end
            AM3_ZPG_X: begin add_base_c = ADDR_WIDTH'(mem_rdata); add_zp_c = 1'b1; add_index_c = x_q; end
            AM3_ABS_X: add_index_c = x_q;
            AM3_ABS_Y: add_index_c = y_q;
            AM3_IND_Y: add_index_c = y_q;
            default:   ;
        endcase
    end

    ea_index_adder #(
        .REG_WIDTH  (REG_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ea_adder (
        .base       (add_base_c),
        .index      (add_index_c),
        .zp_wrap    (add_zp_c),
        .sum        (add_sum_c),
        .page_cross (add_cross_c)
    );

    // Zero-page pointer bytes; the operand byte is still on the bus when leaving OP_LO
    always_comb begin
        ptr_op_c = (state_q == ST_OP_LO) ? mem_rdata : op_q;
        ptr_lo_c = ptr_op_c + ((mode_q == AM3_X_IND) ? x_q : '0);
        ptr_hi_c = ptr_lo_c + REG_WIDTH'(1);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        need_d       = need_q;
        pc_d         = pc_q;
        x_d          = x_q;
        y_d          = y_q;
        op_d         = op_q;
        lo_d         = lo_q;
        ea_d         = ea;
        operand_d    = operand;
        page_cross_d = page_cross;
        pc_adv_d     = pc_adv;
        addr_done_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_OP_LO;
                    mode_d       = am3_e'(opcode_in[4:2]);
                    need_d       = need_data;
                    pc_d         = pc_in;
                    x_d          = x_in;
                    y_d          = y_in;
                    operand_d    = '0;
                    page_cross_d = 1'b0;
                    pc_adv_d     = is_abs_mode(am3_e'(opcode_in[4:2])) ? 2'd2 : 2'd1;
                end
            end
            ST_OP_LO: begin
                if (mem_ack) begin
                    op_d = mem_rdata;
                    lo_d = mem_rdata;
                    if (mode_q == AM3_IMM) begin
                        operand_d   = mem_rdata;
                        addr_done_c = 1'b1;
                    end else if (mode_q == AM3_ZPG || mode_q == AM3_ZPG_X) begin
                        addr_done_c = 1'b1;
                    end else if (is_abs_mode(mode_q)) begin
                        state_d = ST_OP_HI;
                    end else begin
                        state_d = ST_PTR_LO;
                    end
                end
            end
            ST_OP_HI:  if (mem_ack) addr_done_c = 1'b1;
            ST_PTR_LO: begin
                if (mem_ack) begin
                    lo_d    = mem_rdata;
                    state_d = ST_PTR_HI;
                end
            end
            ST_PTR_HI: if (mem_ack) addr_done_c = 1'b1;
            ST_FIXUP:  state_d = need_q ? ST_DATA : ST_DONE;
            ST_DATA: begin
                if (mem_ack) begin
                    operand_d = mem_rdata;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (addr_done_c) begin
            ea_d         = add_sum_c;
            page_cross_d = add_cross_c && can_page_cross(mode_q);
            if (page_cross_d)
                state_d = ST_FIXUP;
            else if (need_q && mode_q != AM3_IMM)
                state_d = ST_DATA;
            else
                state_d = ST_DONE;
        end
    end

    // Bus request for the state being entered, so mem_req/mem_addr come straight from flops
    always_comb begin
        mem_req_d  = 1'b0;
        mem_addr_d = '0;
        case (state_d)
            ST_OP_LO:  begin mem_req_d = 1'b1; mem_addr_d = pc_d + ADDR_WIDTH'(1); end
            ST_OP_HI:  begin mem_req_d = 1'b1; mem_addr_d = pc_q + ADDR_WIDTH'(2); end
            ST_PTR_LO: begin mem_req_d = 1'b1; mem_addr_d = ADDR_WIDTH'(ptr_lo_c); end
            ST_PTR_HI: begin mem_req_d = 1'b1; mem_addr_d = ADDR_WIDTH'(ptr_hi_c); end
            ST_DATA:   begin mem_req_d = 1'b1; mem_addr_d = ea_d; end
            default:   ;
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= AM3_X_IND;
            need_q     <= 1'b0;
            pc_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            op_q       <= '0;
            lo_q       <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ea         <= '0;
            operand    <= '0;
            page_cross <= 1'b0;
            pc_adv     <= 2'd0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            need_q     <= need_d;
            pc_q       <= pc_d;
            x_q        <= x_d;
            y_q        <= y_d;
            op_q       <= op_d;
            lo_q       <= lo_d;
            mem_req    <= mem_req_d;
            mem_addr   <= mem_addr_d;
            busy       <= (state_d != ST_IDLE);
            done       <= (state_d == ST_DONE);
            ea         <= ea_d;
            operand    <= operand_d;
            page_cross <= page_cross_d;
            pc_adv     <= pc_adv_d;
        end
    end

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// Directed bench for addr_mode_sequencer with a byte memory and programmable ack wait states.
module tb_addr_mode_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  opcode_in;
    logic        need_data;
    logic [15:0] pc_in;
    logic [7:0]  x_in, y_in;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        busy, done;
    logic [15:0] ea;
    logic [7:0]  operand;
    logic        page_cross;
    logic [1:0]  pc_adv;
    logic [2:0]  add_mode;

    logic [7:0]  mem [0:65535];
    int          waits;
    int          wcnt;
    int          n_cmp;
    int          n_err;
    logic [15:0] acc [0:31];
    int          nacc;

    addr_mode_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .opcode_in  (opcode_in),
        .need_data  (need_data),
        .pc_in      (pc_in),
        .x_in       (x_in),
        .y_in       (y_in),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .ea         (ea),
        .operand    (operand),
        .page_cross (page_cross),
        .pc_adv     (pc_adv),
        .add_mode   (add_mode)
    );

    always #5 clk = ~clk;

    // Memory responder: ack after 'waits' idle cycles of a held request
    assign mem_ack   = mem_req && (wcnt >= waits);
    assign mem_rdata = mem[mem_addr];

    always_ff @(posedge clk) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_junk();
        opcode_in = 8'hAD;
        need_data = 1'b1;
        pc_in     = 16'hDEAD;
        x_in      = 8'hEE;
        y_in      = 8'hEE;
    endtask

    // One transaction; lat is the cycle (relative to the start cycle T) where done is seen
    task automatic run_txn(input logic [7:0] opc, input logic nd, input logic [15:0] pc,
                           input logic [7:0] xv, input logic [7:0] yv, input int glitch_lat,
                           output int lat, output int gaps);
        @(negedge clk);
        start = 1'b1; opcode_in = opc; need_data = nd; pc_in = pc; x_in = xv; y_in = yv;
        @(negedge clk);
        start = 1'b0;
        drive_junk();
        lat  = 1;
        gaps = 0;
        nacc = 0;
        while (lat <= 200) begin
            if (done) break;
            if (busy && !mem_req) gaps++;
            if (mem_req && mem_ack && nacc < 32) begin
                acc[nacc] = mem_addr;
                nacc++;
            end
            start = (lat == glitch_lat);
            @(negedge clk);
            lat++;
        end
        // Start in the DONE cycle must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, gaps, found, dones;
        n_cmp = 0; n_err = 0; waits = 0; nacc = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        reset = 1'b1;
        start = 1'b1;
        opcode_in = 8'hA9; need_data = 1'b1; pc_in = 16'h0200; x_in = 8'h00; y_in = 8'h00;

        // Reset with start held high: reset wins
        repeat (3) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ea", 32'(ea), 32'd0);
        chk("rst_operand", 32'(operand), 32'd0);
        chk("rst_page_cross", 32'(page_cross), 32'd0);
        chk("rst_pc_adv", 32'(pc_adv), 32'd0);
        chk("rst_add_mode", 32'(add_mode), 32'd0);
        @(negedge clk);
        chk("rst_start_discarded", 32'(busy), 32'd0);

        // IMM
        mem[16'h0201] = 8'h42;
        run_txn(8'hA9, 1'b1, 16'h0200, 8'h00, 8'h00, 0, lat, gaps);
        chk("imm_lat", 32'(lat), 32'd2);
        chk("imm_operand", 32'(operand), 32'h42);
        chk("imm_ea", 32'(ea), 32'h0201);
        chk("imm_pc_adv", 32'(pc_adv), 32'd1);
        chk("imm_mode", 32'(add_mode), 32'd2);
        chk("imm_naccess", 32'(nacc), 32'd1);

        // ZPG_X with zero-page wrap
        mem[16'h0301] = 8'hF0;
        mem[16'h0010] = 8'h77;
        run_txn(8'hB5, 1'b1, 16'h0300, 8'h20, 8'h00, 0, lat, gaps);
        chk("zpgx_lat", 32'(lat), 32'd3);
        chk("zpgx_ea", 32'(ea), 32'h0010);
        chk("zpgx_data_addr", 32'(acc[1]), 32'h0010);
        chk("zpgx_operand", 32'(operand), 32'h77);
        chk("zpgx_page_cross", 32'(page_cross), 32'd0);
        chk("zpgx_mode", 32'(add_mode), 32'd5);

        // ZPG, no data
        mem[16'h0601] = 8'h34;
        run_txn(8'hA5, 1'b0, 16'h0600, 8'h00, 8'h00, 0, lat, gaps);
        chk("zpg_lat", 32'(lat), 32'd2);
        chk("zpg_ea", 32'(ea), 32'h0034);
        chk("zpg_operand", 32'(operand), 32'h00);

        // ABS_X with page cross and data
        mem[16'h0401] = 8'hFF;
        mem[16'h0402] = 8'h12;
        mem[16'h1300] = 8'h5A;
        run_txn(8'hBD, 1'b1, 16'h0400, 8'h01, 8'h00, 0, lat, gaps);
        chk("absx_lat", 32'(lat), 32'd5);
        chk("absx_ea", 32'(ea), 32'h1300);
        chk("absx_page_cross", 32'(page_cross), 32'd1);
        chk("absx_fixup_cycles", 32'(gaps), 32'd1);
        chk("absx_operand", 32'(operand), 32'h5A);
        chk("absx_pc_adv", 32'(pc_adv), 32'd2);
        chk("absx_hi_addr", 32'(acc[1]), 32'h0402);

        // IND_Y with pointer wrap, no data
        mem[16'h0501] = 8'hFF;
        mem[16'h00FF] = 8'h00;
        mem[16'h0000] = 8'h30;
        run_txn(8'hB1, 1'b0, 16'h0500, 8'h00, 8'h05, 0, lat, gaps);
        chk("indy_lat", 32'(lat), 32'd4);
        chk("indy_ptr_lo_addr", 32'(acc[1]), 32'h00FF);
        chk("indy_ptr_hi_addr", 32'(acc[2]), 32'h0000);
        chk("indy_ea", 32'(ea), 32'h3005);
        chk("indy_page_cross", 32'(page_cross), 32'd0);
        chk("indy_operand", 32'(operand), 32'h00);

        // ABS_Y with a start pulse while busy
        mem[16'h0801] = 8'h00;
        mem[16'h0802] = 8'h20;
        mem[16'h2010] = 8'hC3;
        run_txn(8'hB9, 1'b1, 16'h0800, 8'h00, 8'h10, 2, lat, gaps);
        chk("absy_lat", 32'(lat), 32'd4);
        chk("absy_ea", 32'(ea), 32'h2010);
        chk("absy_operand", 32'(operand), 32'hC3);
        chk("absy_mode", 32'(add_mode), 32'd6);
        @(negedge clk);
        chk("absy_ea_held", 32'(ea), 32'h2010);
        chk("absy_still_idle", 32'(busy), 32'd0);

        // X_IND, 3 wait states, reset during PTR_HI
        waits = 3;
        mem[16'h0701] = 8'h10;
        mem[16'h0015] = 8'h34;
        mem[16'h0016] = 8'h12;
        mem[16'h1234] = 8'h99;
        @(negedge clk);
        start = 1'b1; opcode_in = 8'hA1; need_data = 1'b1; pc_in = 16'h0700; x_in = 8'h05; y_in = 8'h00;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (mem_req && mem_addr == 16'h0016) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("xind_reached_ptr_hi", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("xind_rst_mem_req", 32'(mem_req), 32'd0);
        chk("xind_rst_busy", 32'(busy), 32'd0);
        chk("xind_rst_ea", 32'(ea), 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("xind_no_done_after_rst", 32'(dones), 32'd0);

        run_txn(8'hA1, 1'b1, 16'h0700, 8'h05, 8'h00, 0, lat, gaps);
        chk("xind_lat", 32'(lat), 32'd17);
        chk("xind_ptr_lo_addr", 32'(acc[1]), 32'h0015);
        chk("xind_ptr_hi_addr", 32'(acc[2]), 32'h0016);
        chk("xind_ea", 32'(ea), 32'h1234);
        chk("xind_operand", 32'(operand), 32'h99);
        chk("xind_pc_adv", 32'(pc_adv), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
